// File: rtl/grf_mp.sv
// Multi-port general register file for the pipelined MIPS core: NRD combinational
// read ports, two prioritised write ports, optional write bypass and a busy scoreboard.
module grf_mp #(
  parameter int unsigned DW     = 32,
  parameter int unsigned NREG   = 32,
  parameter int unsigned AW     = 5,
  parameter int unsigned NRD    = 2,
  parameter int unsigned BYPASS = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NRD*AW-1:0] ra,
  output logic [NRD*DW-1:0] rdata,
  output logic [NRD-1:0]    rbusy,
  input  logic              we0,
  input  logic [AW-1:0]     wa0,
  input  logic [DW-1:0]     wd0,
  input  logic              we1,
  input  logic [AW-1:0]     wa1,
  input  logic [DW-1:0]     wd1,
  input  logic              set_en,
  input  logic [AW-1:0]     set_addr,
  output logic [NREG-1:0]   busy_vec
);

  localparam int unsigned DEPTH  = 1 << AW;
  localparam logic [AW:0] NREG_A = (AW+1)'(NREG);

  // Storage spans the full address space so any AW-bit address indexes safely;
  // entries 0 and >= NREG are pinned to zero.
  logic [DW-1:0]    regs [DEPTH];
  logic [DEPTH-1:0] busy;

  logic w0_ok, w1_ok, set_ok;

  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (a != '0) && ({1'b0, a} < NREG_A);
  endfunction

  assign w0_ok  = we0 && addr_ok(wa0);
  assign w1_ok  = we1 && addr_ok(wa1);
  assign set_ok = set_en && addr_ok(set_addr);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) regs[i] <= '0;
      busy <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (i == 0 || i >= NREG) begin
          regs[i] <= '0;
          busy[i] <= 1'b0;
        end else begin
          if (w1_ok && wa1 == AW'(i))      regs[i] <= wd1;
          else if (w0_ok && wa0 == AW'(i)) regs[i] <= wd0;
          // A newly issued producer is younger than any retiring one.
          if (set_ok && set_addr == AW'(i))
            busy[i] <= 1'b1;
          else if ((w0_ok && wa0 == AW'(i)) || (w1_ok && wa1 == AW'(i)))
            busy[i] <= 1'b0;
        end
      end
    end
  end

  assign busy_vec = busy[NREG-1:0];

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          b, h0, h1, hs;

    assign a = ra[k*AW +: AW];

    always_comb begin
      h0 = w0_ok && (wa0 == a);
      h1 = w1_ok && (wa1 == a);
      hs = set_ok && (set_addr == a);
      d  = '0;
      b  = 1'b0;
      if (addr_ok(a)) begin
        d = regs[a];
        b = busy[a];
        if (BYPASS != 0) begin
          if (h1)      d = wd1;
          else if (h0) d = wd0;
          if ((h0 || h1) && !hs) b = 1'b0;
        end
      end
    end

    assign rdata[k*DW +: DW] = d;
    assign rbusy[k]          = b;
  end

endmodule

// File: tb/tb_grf_mp.sv
// Bench for grf_mp: three configurations (bypass, no bypass, 16 regs / 3 ports)
// driven in lockstep and compared against an array-based register file model.
module tb_grf_mp;

  logic        clk = 1'b0;
  logic        reset;
  logic        we0, we1, set_en;
  logic [4:0]  wa0, wa1, set_addr;
  logic [31:0] wd0, wd1;
  logic [9:0]  ra_ab;
  logic [14:0] ra_c;

  logic [63:0] rdata_a, rdata_b;
  logic [95:0] rdata_c;
  logic [1:0]  rbusy_a, rbusy_b;
  logic [2:0]  rbusy_c;
  logic [31:0] busy_a, busy_b;
  logic [15:0] busy_c;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  grf_mp dut_a (
    .clk(clk), .reset(reset), .ra(ra_ab), .rdata(rdata_a), .rbusy(rbusy_a),
    .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
    .set_en(set_en), .set_addr(set_addr), .busy_vec(busy_a)
  );

  grf_mp #(.BYPASS(0)) dut_b (
    .clk(clk), .reset(reset), .ra(ra_ab), .rdata(rdata_b), .rbusy(rbusy_b),
    .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
    .set_en(set_en), .set_addr(set_addr), .busy_vec(busy_b)
  );

  grf_mp #(.NREG(16), .AW(5), .NRD(3)) dut_c (
    .clk(clk), .reset(reset), .ra(ra_c), .rdata(rdata_c), .rbusy(rbusy_c),
    .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
    .set_en(set_en), .set_addr(set_addr), .busy_vec(busy_c)
  );

  // Model: index 0 holds a 32-register file, index 1 a 16-register file.
  logic [31:0] mv [2][32];
  bit          mb [2][32];

  function automatic int nreg_of(input int c);
    return (c == 0) ? 32 : 16;
  endfunction

  function automatic bit valid(input int c, input logic [4:0] a);
    return (a != 0) && (int'(a) < nreg_of(c));
  endfunction

  function automatic logic [31:0] exp_rd(input int c, input bit byp, input logic [4:0] a);
    if (!valid(c, a)) return 32'h0;
    if (byp && we1 && wa1 == a) return wd1;
    if (byp && we0 && wa0 == a) return wd0;
    return mv[c][a];
  endfunction

  function automatic logic exp_rb(input int c, input bit byp, input logic [4:0] a);
    bit writing;
    if (!valid(c, a)) return 1'b0;
    writing = (we0 && wa0 == a) || (we1 && wa1 == a);
    if (byp && writing && !(set_en && set_addr == a)) return 1'b0;
    return mb[c][a];
  endfunction

  function automatic logic [31:0] exp_bv(input int c);
    logic [31:0] v = '0;
    for (int r = 0; r < nreg_of(c); r++) v[r] = mb[c][r];
    return v;
  endfunction

  task automatic model_step();
    for (int c = 0; c < 2; c++) begin
      if (reset) begin
        for (int r = 0; r < 32; r++) begin mv[c][r] = 0; mb[c][r] = 0; end
      end else begin
        if (we0 && valid(c, wa0)) begin mv[c][wa0] = wd0; mb[c][wa0] = 0; end
        if (we1 && valid(c, wa1)) begin mv[c][wa1] = wd1; mb[c][wa1] = 0; end
        if (set_en && valid(c, set_addr)) mb[c][set_addr] = 1;
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("a.rdata%0d", k), rdata_a[k*32 +: 32], exp_rd(0, 1, ra_ab[k*5 +: 5]));
      check($sformatf("a.rbusy%0d", k), 32'(rbusy_a[k]), 32'(exp_rb(0, 1, ra_ab[k*5 +: 5])));
      check($sformatf("b.rdata%0d", k), rdata_b[k*32 +: 32], exp_rd(0, 0, ra_ab[k*5 +: 5]));
      check($sformatf("b.rbusy%0d", k), 32'(rbusy_b[k]), 32'(exp_rb(0, 0, ra_ab[k*5 +: 5])));
    end
    for (int k = 0; k < 3; k++) begin
      check($sformatf("c.rdata%0d", k), rdata_c[k*32 +: 32], exp_rd(1, 1, ra_c[k*5 +: 5]));
      check($sformatf("c.rbusy%0d", k), 32'(rbusy_c[k]), 32'(exp_rb(1, 1, ra_c[k*5 +: 5])));
    end
    check("a.busy_vec", busy_a, exp_bv(0));
    check("b.busy_vec", busy_b, exp_bv(0));
    check("c.busy_vec", 32'(busy_c), exp_bv(1));
  endtask

  // One clock: check at the falling edge, advance the model, drive after the rising edge.
  task automatic step(input bit chk);
    @(negedge clk);
    if (chk) check_all();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reset = 0; we0 = 0; we1 = 0; set_en = 0;
    wa0 = 0; wa1 = 0; wd0 = 0; wd1 = 0; set_addr = 0;
  endtask

  task automatic rd(input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2);
    ra_ab = {a1, a0};
    ra_c  = {a2, a1, a0};
  endtask

  initial begin
    idle();
    rd(0, 0, 0);
    reset = 1;
    step(0);
    step(1);
    reset = 0;

    // Basic write then read; register 0 stays zero.
    we0 = 1; wa0 = 5; wd0 = 32'h1234_5678; rd(5, 0, 5);
    step(1);
    idle(); step(1);
    we0 = 1; wa0 = 0; wd0 = 32'hFFFF_FFFF; rd(0, 5, 0);
    step(1);
    idle(); step(1);

    // Same-cycle write collision on reg 7 with a same-cycle read.
    we0 = 1; we1 = 1; wa0 = 7; wa1 = 7; wd0 = 32'hAAAA; wd1 = 32'hBBBB; rd(7, 5, 7);
    step(1);
    idle(); step(1);

    // Scoreboard: set, observe, clear by write, then set+write together.
    set_en = 1; set_addr = 9; rd(9, 7, 9);
    step(1);
    idle(); step(1);
    we0 = 1; wa0 = 9; wd0 = 32'h0000_0099;
    step(1);
    idle(); step(1);
    set_en = 1; set_addr = 9; we0 = 1; wa0 = 9; wd0 = 32'h0000_9999;
    step(1);
    idle(); step(1);

    // Reset mid-stall with a write presented in the reset cycle.
    we0 = 1; wa0 = 3; wd0 = 32'h33; we1 = 1; wa1 = 4; wd1 = 32'h44; rd(3, 4, 3);
    step(1);
    idle(); set_en = 1; set_addr = 3; step(1);
    idle(); set_en = 1; set_addr = 4; step(1);
    idle(); step(1);
    reset = 1; we1 = 1; wa1 = 3; wd1 = 32'hDEAD_BEEF;
    step(0);
    idle(); step(1);
    rd(9, 7, 5); step(1);

    // Sixteen-register instance: out-of-range write and three independent ports.
    we0 = 1; wa0 = 20; wd0 = 32'h2020_2020; we1 = 1; wa1 = 1; wd1 = 32'h1111; rd(20, 1, 20);
    step(1);
    idle(); we0 = 1; wa0 = 2; wd0 = 32'h2222; we1 = 1; wa1 = 15; wd1 = 32'hF0F0;
    step(1);
    idle(); rd(1, 2, 15); step(1);
    rd(20, 15, 2); step(1);

    // Randomised traffic concentrated on a few addresses to provoke collisions.
    for (int n = 0; n < 400; n++) begin
      reset    = ($urandom_range(0, 59) == 0);
      we0      = $urandom_range(0, 1);
      we1      = $urandom_range(0, 1);
      set_en   = ($urandom_range(0, 9) < 4);
      wa0      = 5'($urandom_range(0, 7) == 0 ? $urandom_range(0, 31) : $urandom_range(0, 17));
      wa1      = 5'($urandom_range(0, 17));
      set_addr = 5'($urandom_range(0, 7) == 0 ? $urandom_range(0, 31) : $urandom_range(0, 17));
      wd0      = $urandom;
      wd1      = $urandom;
      rd(5'($urandom_range(0, 31)), 5'($urandom_range(0, 17)), 5'($urandom_range(0, 17)));
      if ($urandom_range(0, 3) == 0) ra_ab[4:0] = wa0;
      if ($urandom_range(0, 3) == 0) ra_c[14:10] = wa1;
      step(1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
